// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM bank sequencer: command encodings,
// sequencer FSM states, open-row lookup classes and a small max helper.
package dram_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_PRE = 3'd1,
    CMD_ACT = 3'd2,
    CMD_RD  = 3'd3,
    CMD_WR  = 3'd4
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_PRE_W = 3'd2,
    ST_ACT   = 3'd3,
    ST_ACT_W = 3'd4,
    ST_RW    = 3'd5,
    ST_RW_W  = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  // Result of looking a (bank,row) pair up in the open-row table
  typedef enum logic [1:0] {
    CLS_HIT      = 2'd0,
    CLS_CLOSED   = 2'd1,
    CLS_CONFLICT = 2'd2
  } row_class_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/dram_open_row_table.sv
// Per-bank open-row tracker.
//  clk, rst        : clock, synchronous active-high reset (closes all banks)
//  lkp_bank/row    : combinational lookup key
//  lkp_class_c     : hit / closed / conflict for the lookup key
//  clr_en/clr_bank : mark a bank closed at the next edge (precharge)
//  set_en/set_bank/set_row : mark a bank open on a row at the next edge (activate)
module dram_open_row_table
  import dram_pkg::*;
#(
  parameter int unsigned NUM_OF_BANKS = 8,
  parameter int unsigned NUM_OF_ROWS  = 128
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [$clog2(NUM_OF_BANKS)-1:0] lkp_bank,
  input  logic [$clog2(NUM_OF_ROWS)-1:0]  lkp_row,
  output row_class_e                      lkp_class_c,
  input  logic                            clr_en,
  input  logic [$clog2(NUM_OF_BANKS)-1:0] clr_bank,
  input  logic                            set_en,
  input  logic [$clog2(NUM_OF_BANKS)-1:0] set_bank,
  input  logic [$clog2(NUM_OF_ROWS)-1:0]  set_row
);

  localparam int unsigned RW = $clog2(NUM_OF_ROWS);

  logic [NUM_OF_BANKS-1:0] open_q, open_d;
  logic [RW-1:0]           row_q [NUM_OF_BANKS];
  logic [RW-1:0]           row_d [NUM_OF_BANKS];

  // Lookup against the current table contents
  always_comb begin
    lkp_class_c = CLS_CLOSED;
    if (open_q[lkp_bank]) begin
      lkp_class_c = (row_q[lkp_bank] == lkp_row) ? CLS_HIT : CLS_CONFLICT;
    end
  end

  // Table update: set wins if both target the same bank (never happens in practice)
  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    if (clr_en) open_d[clr_bank] = 1'b0;
    if (set_en) begin
      open_d[set_bank] = 1'b1;
      row_d[set_bank]  = set_row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      open_q <= '0;
      for (int i = 0; i < int'(NUM_OF_BANKS); i++) row_q[i] <= '0;
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
    end
  end

endmodule

// File: rtl/dram_bank_sequencer.sv
// DRAM bank sequencer: takes one decoded request at a time and issues the
// PRE/ACT/RD/WR command sequence with exact tRP/tRCD/tCAS spacing, using an
// open-page policy tracked per bank.
//  clk, rst                        : clock, synchronous active-high reset
//  req_valid/req_ready             : request handshake (ready only in IDLE)
//  req_write, bank_id/row_id/col_id: request payload, stable until accepted
//  cmd_valid, cmd, cmd_bank/row/col: one DRAM command per cycle
//  rsp_done, rsp_hit               : completion pulse and row-hit flag
module dram_bank_sequencer
  import dram_pkg::*;
#(
  parameter int unsigned NUM_OF_BANKS = 8,
  parameter int unsigned NUM_OF_ROWS  = 128,
  parameter int unsigned NUM_OF_COLS  = 8,
  parameter int unsigned T_RP         = 3,
  parameter int unsigned T_RCD        = 3,
  parameter int unsigned T_CAS        = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [$clog2(NUM_OF_BANKS)-1:0] bank_id,
  input  logic [$clog2(NUM_OF_ROWS)-1:0]  row_id,
  input  logic [$clog2(NUM_OF_COLS)-1:0]  col_id,
  output logic                            cmd_valid,
  output logic [2:0]                      cmd,
  output logic [$clog2(NUM_OF_BANKS)-1:0] cmd_bank,
  output logic [$clog2(NUM_OF_ROWS)-1:0]  cmd_row,
  output logic [$clog2(NUM_OF_COLS)-1:0]  cmd_col,
  output logic                            rsp_done,
  output logic                            rsp_hit
);

  localparam int unsigned BW    = $clog2(NUM_OF_BANKS);
  localparam int unsigned RW    = $clog2(NUM_OF_ROWS);
  localparam int unsigned CW    = $clog2(NUM_OF_COLS);
  localparam int unsigned T_MAX = max3(T_RP, T_RCD, T_CAS);
  localparam int unsigned CNT_W = $clog2(T_MAX) + 1;

  state_e        state_q, state_d;
  logic          wr_q, wr_d;
  logic [BW-1:0] bank_q, bank_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          hit_q, hit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic          req_ready_q, req_ready_d;
  logic          cmd_valid_q, cmd_valid_d;
  cmd_e          cmd_q, cmd_d;
  logic [BW-1:0] cmd_bank_q, cmd_bank_d;
  logic [RW-1:0] cmd_row_q, cmd_row_d;
  logic [CW-1:0] cmd_col_q, cmd_col_d;
  logic          rsp_done_q, rsp_done_d;
  logic          rsp_hit_q, rsp_hit_d;

  row_class_e    lkp_class_c;
  logic          tbl_clr_c, tbl_set_c;

  dram_open_row_table #(
    .NUM_OF_BANKS(NUM_OF_BANKS),
    .NUM_OF_ROWS (NUM_OF_ROWS)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .lkp_bank   (bank_id),
    .lkp_row    (row_id),
    .lkp_class_c(lkp_class_c),
    .clr_en     (tbl_clr_c),
    .clr_bank   (bank_q),
    .set_en     (tbl_set_c),
    .set_bank   (bank_q),
    .set_row    (row_q)
  );

  // Next state, capture, wait counter and table writes.
  // Wait states exit on the cycle the counter steps from 1 to 0, giving exact spacing.
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    bank_d    = bank_q;
    row_d     = row_q;
    col_d     = col_q;
    hit_d     = hit_q;
    cnt_d     = cnt_q;
    tbl_clr_c = 1'b0;
    tbl_set_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d   = req_write;
          bank_d = bank_id;
          row_d  = row_id;
          col_d  = col_id;
          hit_d  = (lkp_class_c == CLS_HIT);
          unique case (lkp_class_c)
            CLS_HIT:    state_d = ST_RW;
            CLS_CLOSED: state_d = ST_ACT;
            default:    state_d = ST_PRE;
          endcase
        end
      end
      ST_PRE: begin
        tbl_clr_c = 1'b1;
        cnt_d     = CNT_W'(T_RP - 1);
        state_d   = (T_RP <= 1) ? ST_ACT : ST_PRE_W;
      end
      ST_ACT: begin
        tbl_set_c = 1'b1;
        cnt_d     = CNT_W'(T_RCD - 1);
        state_d   = (T_RCD <= 1) ? ST_RW : ST_ACT_W;
      end
      ST_RW: begin
        cnt_d   = CNT_W'(T_CAS - 1);
        state_d = (T_CAS <= 1) ? ST_DONE : ST_RW_W;
      end
      ST_PRE_W, ST_ACT_W, ST_RW_W: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d = '0;
          unique case (state_q)
            ST_PRE_W: state_d = ST_ACT;
            ST_ACT_W: state_d = ST_RW;
            default:  state_d = ST_DONE;
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore output decode of the upcoming state so outputs leave a flop
  always_comb begin
    req_ready_d = 1'b0;
    cmd_valid_d = 1'b0;
    cmd_d       = CMD_NOP;
    cmd_bank_d  = '0;
    cmd_row_d   = '0;
    cmd_col_d   = '0;
    rsp_done_d  = 1'b0;
    rsp_hit_d   = 1'b0;
    unique case (state_d)
      ST_IDLE: req_ready_d = 1'b1;
      ST_PRE: begin
        cmd_valid_d = 1'b1;
        cmd_d       = CMD_PRE;
        cmd_bank_d  = bank_d;
      end
      ST_ACT: begin
        cmd_valid_d = 1'b1;
        cmd_d       = CMD_ACT;
        cmd_bank_d  = bank_d;
        cmd_row_d   = row_d;
      end
      ST_RW: begin
        cmd_valid_d = 1'b1;
        cmd_d       = wr_d ? CMD_WR : CMD_RD;
        cmd_bank_d  = bank_d;
        cmd_col_d   = col_d;
      end
      ST_DONE: begin
        rsp_done_d = 1'b1;
        rsp_hit_d  = hit_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      bank_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      hit_q       <= 1'b0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NOP;
      cmd_bank_q  <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      rsp_done_q  <= 1'b0;
      rsp_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      bank_q      <= bank_d;
      row_q       <= row_d;
      col_q       <= col_d;
      hit_q       <= hit_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      cmd_bank_q  <= cmd_bank_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
      rsp_done_q  <= rsp_done_d;
      rsp_hit_q   <= rsp_hit_d;
    end
  end

  assign req_ready = req_ready_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign cmd_bank  = cmd_bank_q;
  assign cmd_row   = cmd_row_q;
  assign cmd_col   = cmd_col_q;
  assign rsp_done  = rsp_done_q;
  assign rsp_hit   = rsp_hit_q;

endmodule

// File: tb/tb_dram_bank_sequencer.sv
// Self-checking bench for dram_bank_sequencer. Expected per-cycle output
// traces come from a per-bank open-row model and the latency rules.
module tb_dram_bank_sequencer;

  localparam int T_RP  = 3;
  localparam int T_RCD = 3;
  localparam int T_CAS = 2;
  localparam int VW    = 20;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [2:0] bank_id;
  logic [6:0] row_id;
  logic [2:0] col_id;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [2:0] cmd_bank;
  logic [6:0] cmd_row;
  logic [2:0] cmd_col;
  logic       rsp_done;
  logic       rsp_hit;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit         mopen [8];
  logic [6:0] mrow  [8];
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] obs_q[$];

  dram_bank_sequencer #(
    .NUM_OF_BANKS(8), .NUM_OF_ROWS(128), .NUM_OF_COLS(8),
    .T_RP(T_RP), .T_RCD(T_RCD), .T_CAS(T_CAS)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .bank_id(bank_id), .row_id(row_id), .col_id(col_id),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bank(cmd_bank),
    .cmd_row(cmd_row), .cmd_col(cmd_col),
    .rsp_done(rsp_done), .rsp_hit(rsp_hit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {ready, valid, cmd, bank, row, col, done, hit}
  function automatic logic [VW-1:0] mk(input bit rdy, input bit v, input logic [2:0] cm,
                                       input logic [2:0] b, input logic [6:0] r,
                                       input logic [2:0] c, input bit d, input bit h);
    return {rdy, v, cm, b, r, c, d, h};
  endfunction

  function automatic logic [VW-1:0] cur_vec();
    return {req_ready, cmd_valid, cmd, cmd_bank, cmd_row, cmd_col, rsp_done, rsp_hit};
  endfunction

  function automatic logic [VW-1:0] idle_vec();
    return mk(1'b1, 1'b0, 3'd0, 3'd0, 7'd0, 3'd0, 1'b0, 1'b0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mopen[i] = 1'b0;
      mrow[i]  = '0;
    end
  endtask

  // Builds the expected trace for cycles 1..done+1 after accept and updates the model
  task automatic model_req(input bit w, input logic [2:0] b, input logic [6:0] r,
                           input logic [2:0] c, output int ncyc, output bit hit);
    int pre_at, act_at, rw_at, done_at;
    logic [VW-1:0] v;
    pre_at = -1;
    act_at = -1;
    hit = mopen[b] && (mrow[b] == r);
    if (hit) begin
      rw_at = 1;
    end else if (!mopen[b]) begin
      act_at = 1;
      rw_at  = 1 + T_RCD;
    end else begin
      pre_at = 1;
      act_at = 1 + T_RP;
      rw_at  = act_at + T_RCD;
    end
    done_at = rw_at + T_CAS;
    exp_q.delete();
    for (int k = 1; k <= done_at + 1; k++) begin
      v = mk(k == done_at + 1, 1'b0, 3'd0, 3'd0, 7'd0, 3'd0, 1'b0, 1'b0);
      if (k == pre_at) v = mk(1'b0, 1'b1, 3'd1, b, 7'd0, 3'd0, 1'b0, 1'b0);
      if (k == act_at) v = mk(1'b0, 1'b1, 3'd2, b, r, 3'd0, 1'b0, 1'b0);
      if (k == rw_at)  v = mk(1'b0, 1'b1, w ? 3'd4 : 3'd3, b, 7'd0, c, 1'b0, 1'b0);
      if (k == done_at) v = mk(1'b0, 1'b0, 3'd0, 3'd0, 7'd0, 3'd0, 1'b1, hit);
      exp_q.push_back(v);
    end
    mopen[b] = 1'b1;
    mrow[b]  = r;
    ncyc = done_at + 1;
  endtask

  // Presents a request (starting at a negedge), records outputs for ncyc cycles after accept
  task automatic drive_req(input bit w, input logic [2:0] b, input logic [6:0] r,
                           input logic [2:0] c, input int ncyc, input bit hold,
                           output bit acc);
    int waitc;
    waitc = 0;
    acc = 1'b0;
    obs_q.delete();
    req_valid = 1'b1;
    req_write = w;
    bank_id   = b;
    row_id    = r;
    col_id    = c;
    while (!acc && waitc < 30) begin
      if (req_ready === 1'b1) acc = 1'b1;
      @(negedge clk);
      waitc++;
    end
    if (!acc) begin
      req_valid = 1'b0;
      return;
    end
    if (!hold) req_valid = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      if (k > 1) @(negedge clk);
      obs_q.push_back(cur_vec());
      if (k == ncyc - 1) req_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    bank_id = '0;
    row_id = '0;
    col_id = '0;
    model_reset();
    repeat (2) @(negedge clk);
    total++;
    if (cur_vec() !== idle_vec()) begin
      bad++;
      $display("FAIL reset_state got=%h exp=%h", cur_vec(), idle_vec());
    end
    // reset must win over a pending request
    req_valid = 1'b1;
    bank_id = 3'd1;
    @(negedge clk);
    total++;
    if (cur_vec() !== idle_vec()) begin
      bad++;
      $display("FAIL reset_priority got=%h exp=%h", cur_vec(), idle_vec());
    end
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cur_vec() !== idle_vec()) begin
      bad++;
      $display("FAIL post_reset_idle got=%h exp=%h", cur_vec(), idle_vec());
    end
  endtask

  task automatic test_closed_read();
    int n; bit h; bit acc;
    model_req(1'b0, 3'd3, 7'd5, 3'd2, n, h);
    drive_req(1'b0, 3'd3, 7'd5, 3'd2, n, 1'b0, acc);
    total++;
    if (acc !== 1'b1) begin bad++; $display("FAIL closed_accept got=%0b exp=1", acc); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [VW-1:0] o;
      o = (i < obs_q.size()) ? obs_q[i] : 'x;
      total++;
      if (o !== exp_q[i]) begin
        bad++;
        $display("FAIL closed_read cyc%0d got=%h exp=%h", i + 1, o, exp_q[i]);
      end
    end
  endtask

  task automatic test_hit_write();
    int n; bit h; bit acc;
    model_req(1'b1, 3'd3, 7'd5, 3'd7, n, h);
    drive_req(1'b1, 3'd3, 7'd5, 3'd7, n, 1'b0, acc);
    total++;
    if (n !== 4 || h !== 1'b1) begin
      bad++;
      $display("FAIL hit_model got=%0d/%0b exp=4/1", n, h);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [VW-1:0] o;
      o = (i < obs_q.size()) ? obs_q[i] : 'x;
      total++;
      if (o !== exp_q[i]) begin
        bad++;
        $display("FAIL hit_write cyc%0d got=%h exp=%h", i + 1, o, exp_q[i]);
      end
    end
  endtask

  // Conflict with req_valid held high: ready must stay low and only one accept occurs
  task automatic test_conflict_hold();
    int n; bit h; bit acc;
    model_req(1'b0, 3'd3, 7'd9, 3'd4, n, h);
    drive_req(1'b0, 3'd3, 7'd9, 3'd4, n, 1'b1, acc);
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [VW-1:0] o;
      o = (i < obs_q.size()) ? obs_q[i] : 'x;
      total++;
      if (o !== exp_q[i]) begin
        bad++;
        $display("FAIL conflict_hold cyc%0d got=%h exp=%h", i + 1, o, exp_q[i]);
      end
    end
    @(negedge clk);
    total++;
    if (cur_vec() !== idle_vec()) begin
      bad++;
      $display("FAIL single_accept got=%h exp=%h", cur_vec(), idle_vec());
    end
  endtask

  task automatic test_multi_bank();
    int n; bit h; bit acc;
    logic [2:0] bl [4];
    logic [6:0] rl [4];
    bl[0] = 3'd0; rl[0] = 7'd11;
    bl[1] = 3'd7; rl[1] = 7'd100;
    bl[2] = 3'd0; rl[2] = 7'd11;
    bl[3] = 3'd7; rl[3] = 7'd100;
    for (int j = 0; j < 4; j++) begin
      model_req(1'b0, bl[j], rl[j], 3'(j), n, h);
      drive_req(1'b0, bl[j], rl[j], 3'(j), n, 1'b0, acc);
      if (j >= 2) begin
        total++;
        if (obs_q.size() < n || obs_q[n-2] !== mk(1'b0, 1'b0, 3'd0, 3'd0, 7'd0, 3'd0, 1'b1, 1'b1)) begin
          bad++;
          $display("FAIL multi_bank_hit req%0d got=%h exp=done+hit", j,
                   (obs_q.size() >= n) ? obs_q[n-2] : 'x);
        end
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        logic [VW-1:0] o;
        o = (i < obs_q.size()) ? obs_q[i] : 'x;
        total++;
        if (o !== exp_q[i]) begin
          bad++;
          $display("FAIL multi_bank req%0d cyc%0d got=%h exp=%h", j, i + 1, o, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n; bit h; bit acc;
    req_valid = 1'b1;
    req_write = 1'b0;
    bank_id = 3'd2;
    row_id = 7'd33;
    col_id = 3'd1;
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (cur_vec() !== mk(1'b0, 1'b1, 3'd2, 3'd2, 7'd33, 3'd0, 1'b0, 1'b0)) begin
      bad++;
      $display("FAIL mid_act got=%h exp=%h", cur_vec(),
               mk(1'b0, 1'b1, 3'd2, 3'd2, 7'd33, 3'd0, 1'b0, 1'b0));
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (cur_vec() !== idle_vec()) begin
        bad++;
        $display("FAIL mid_abort cyc%0d got=%h exp=%h", k, cur_vec(), idle_vec());
      end
      @(negedge clk);
    end
    // bank 3 was open on row 9 before reset; both must now look closed
    model_req(1'b1, 3'd3, 7'd9, 3'd6, n, h);
    drive_req(1'b1, 3'd3, 7'd9, 3'd6, n, 1'b0, acc);
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [VW-1:0] o;
      o = (i < obs_q.size()) ? obs_q[i] : 'x;
      total++;
      if (o !== exp_q[i]) begin
        bad++;
        $display("FAIL after_reset cyc%0d got=%h exp=%h", i + 1, o, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int n; bit h; bit acc;
    bit w; logic [2:0] b; logic [6:0] r; logic [2:0] c; bit hold;
    for (int j = 0; j < 40; j++) begin
      w    = 1'($urandom_range(0, 1));
      b    = 3'($urandom_range(0, 7));
      r    = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 2));
      c    = 3'($urandom_range(0, 7));
      hold = 1'($urandom_range(0, 1));
      model_req(w, b, r, c, n, h);
      drive_req(w, b, r, c, n, hold, acc);
      total++;
      if (acc !== 1'b1) begin bad++; $display("FAIL rand_accept req%0d got=%0b exp=1", j, acc); end
      for (int i = 0; i < exp_q.size(); i++) begin
        logic [VW-1:0] o;
        o = (i < obs_q.size()) ? obs_q[i] : 'x;
        total++;
        if (o !== exp_q[i]) begin
          bad++;
          $display("FAIL random req%0d cyc%0d got=%h exp=%h", j, i + 1, o, exp_q[i]);
        end
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_closed_read();
    test_hit_write();
    test_conflict_hold();
    test_multi_bank();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
